// File: rtl/clock_time_setter_if.sv
// Bus between the time-setting control stage and its neighbours: raw buttons,
// the running clock time, and the load / display outputs.
interface clock_time_setter_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [7:0] cur_hh;
  logic [7:0] cur_mm;
  logic [7:0] cur_ss;
  logic       setting;
  logic       load;
  logic [7:0] load_hh;
  logic [7:0] load_mm;
  logic [7:0] load_ss;
  logic [7:0] disp_hh;
  logic [7:0] disp_mm;
  logic [7:0] disp_ss;
  logic [7:0] blank_mask;

  modport slave (
    input  btn_mode, btn_up, btn_down, cur_hh, cur_mm, cur_ss,
    output setting, load, load_hh, load_mm, load_ss,
           disp_hh, disp_mm, disp_ss, blank_mask
  );

  modport master (
    output btn_mode, btn_up, btn_down, cur_hh, cur_mm, cur_ss,
    input  setting, load, load_hh, load_mm, load_ss,
           disp_hh, disp_mm, disp_ss, blank_mask
  );
endinterface

// File: rtl/clock_time_setter.sv
// Button conditioning plus set-mode FSM for the 24h clock: edits hh/mm/ss in
// BCD, blinks the field being edited and strobes a load on exit.
module clock_time_setter #(
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd500_000,
  parameter logic [31:0] BLINK_CYCLES    = 32'd12_500_000
) (
  input logic                clk,
  input logic                reset,
  clock_time_setter_if.slave bus
);
  typedef enum logic [1:0] {RUN, SET_HH, SET_MM, SET_SS} state_e;

  // Button vectors are indexed {down, up, mode}.
  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]       stable_q, stable_d, prev_q, prev_d, press_q, press_d;
  logic [2:0][31:0] deb_cnt_q, deb_cnt_d;

  state_e      state_q, state_d;
  logic [7:0]  hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic        load_q, load_d;
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;
  logic        mode_p, up_p, dn_p, step, adj;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim)         return 8'h00;
    if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lim);
    if (v == 8'h00)       return lim;
    if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Out-of-range or non-BCD running time is captured as 00.
  function automatic logic [7:0] bcd_cap(input logic [7:0] v, input logic [7:0] lim);
    if (v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && v <= lim) return v;
    return 8'h00;
  endfunction

  always_comb begin
    sync1_d   = {bus.btn_down, bus.btn_up, bus.btn_mode};
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEBOUNCE_CYCLES - 32'd1) begin
        stable_d[i]  = ~stable_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 32'd1;
      end
    end
    prev_d  = stable_q;
    press_d = stable_q & ~prev_q;
  end

  assign mode_p = press_q[0];
  assign up_p   = press_q[1];
  assign dn_p   = press_q[2];
  assign step   = up_p ^ dn_p;

  always_comb begin
    state_d = state_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    load_d  = 1'b0;
    adj     = 1'b0;
    case (state_q)
      RUN: if (mode_p) begin
        state_d = SET_HH;
        hh_d    = bcd_cap(bus.cur_hh, 8'h23);
        mm_d    = bcd_cap(bus.cur_mm, 8'h59);
        ss_d    = bcd_cap(bus.cur_ss, 8'h59);
      end
      SET_HH: if (mode_p) state_d = SET_MM;
              else if (step) begin
                adj  = 1'b1;
                hh_d = up_p ? bcd_inc(hh_q, 8'h23) : bcd_dec(hh_q, 8'h23);
              end
      SET_MM: if (mode_p) state_d = SET_SS;
              else if (step) begin
                adj  = 1'b1;
                mm_d = up_p ? bcd_inc(mm_q, 8'h59) : bcd_dec(mm_q, 8'h59);
              end
      SET_SS: if (mode_p) begin
                state_d = RUN;
                load_d  = 1'b1;
              end else if (step) begin
                adj  = 1'b1;
                ss_d = up_p ? bcd_inc(ss_q, 8'h59) : bcd_dec(ss_q, 8'h59);
              end
      default: state_d = RUN;
    endcase
  end

  // Any edit or field change restarts the blink with the field visible.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 32'd1;
    phase_d     = phase_q;
    if (state_q == RUN || state_d != state_q || adj) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_CYCLES - 32'd1) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      prev_q      <= '0;
      press_q     <= '0;
      deb_cnt_q   <= '0;
      state_q     <= RUN;
      hh_q        <= '0;
      mm_q        <= '0;
      ss_q        <= '0;
      load_q      <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      prev_q      <= prev_d;
      press_q     <= press_d;
      deb_cnt_q   <= deb_cnt_d;
      state_q     <= state_d;
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      ss_q        <= ss_d;
      load_q      <= load_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  always_comb begin
    bus.blank_mask = 8'h00;
    case (state_q)
      SET_HH:  bus.blank_mask = {{2{phase_q}}, 6'b0};
      SET_MM:  bus.blank_mask = {3'b0, {2{phase_q}}, 3'b0};
      SET_SS:  bus.blank_mask = {6'b0, {2{phase_q}}};
      default: bus.blank_mask = 8'h00;
    endcase
  end

  assign bus.setting = (state_q != RUN);
  assign bus.load    = load_q;
  assign bus.load_hh = hh_q;
  assign bus.load_mm = mm_q;
  assign bus.load_ss = ss_q;
  assign bus.disp_hh = bus.setting ? hh_q : bus.cur_hh;
  assign bus.disp_mm = bus.setting ? mm_q : bus.cur_mm;
  assign bus.disp_ss = bus.setting ? ss_q : bus.cur_ss;
endmodule

// File: tb/tb_clock_time_setter.sv
// Directed and random button sequences against a decimal-arithmetic model of
// the set-mode behaviour (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8).
module tb_clock_time_setter;
  localparam int DEB   = 4;
  localparam int BLINK = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  clock_time_setter_if bus();

  clock_time_setter #(
    .DEBOUNCE_CYCLES(32'(DEB)),
    .BLINK_CYCLES   (32'(BLINK))
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  // Model: state 0=RUN 1=HH 2=MM 3=SS, edit fields as decimal ints,
  // c = cycles since the blink last restarted.
  int st = 0, eh = 0, em = 0, es = 0, c = 0;
  int exp_loads = 0;
  int load_seen = 0;

  always @(negedge clk) if (bus.load === 1'b1) load_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic int cap(input logic [7:0] v, input int lim);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi < 10 && lo < 10 && hi * 10 + lo <= lim) return hi * 10 + lo;
    return 0;
  endfunction

  function automatic logic [7:0] exp_mask();
    if (st == 0 || ((c / BLINK) % 2) == 0) return 8'h00;
    case (st)
      1:       return 8'hC0;
      2:       return 8'h18;
      default: return 8'h03;
    endcase
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".setting"}, 32'(bus.setting), 32'(st != 0));
    chk({tag, ".disp_hh"}, 32'(bus.disp_hh), 32'(st != 0 ? to_bcd(eh) : bus.cur_hh));
    chk({tag, ".disp_mm"}, 32'(bus.disp_mm), 32'(st != 0 ? to_bcd(em) : bus.cur_mm));
    chk({tag, ".disp_ss"}, 32'(bus.disp_ss), 32'(st != 0 ? to_bcd(es) : bus.cur_ss));
    chk({tag, ".load_hh"}, 32'(bus.load_hh), 32'(to_bcd(eh)));
    chk({tag, ".load_mm"}, 32'(bus.load_mm), 32'(to_bcd(em)));
    chk({tag, ".load_ss"}, 32'(bus.load_ss), 32'(to_bcd(es)));
    chk({tag, ".mask"},    32'(bus.blank_mask), 32'(exp_mask()));
  endtask

  // Clean press: held 8 cycles so the event lands at edge 2+4+1+1 = 8,
  // then released for 8 cycles so the next press starts from idle.
  task automatic do_press(input bit m, input bit u, input bit d, input string tag);
    int st0;
    bit acc, ld;
    st0 = st;
    bus.btn_mode = m; bus.btn_up = u; bus.btn_down = d;
    repeat (7) tick();
    c += 7;
    chk({tag, ".early"}, 32'(bus.setting), 32'(st0 != 0));
    tick();
    c++;
    acc = 1'b0; ld = 1'b0;
    if (m) begin
      acc = 1'b1;
      case (st)
        0: begin
          eh = cap(bus.cur_hh, 23); em = cap(bus.cur_mm, 59); es = cap(bus.cur_ss, 59);
          st = 1;
        end
        3: begin st = 0; ld = 1'b1; exp_loads++; end
        default: st++;
      endcase
    end else if (st != 0 && (u ^ d)) begin
      acc = 1'b1;
      case (st)
        1:       eh = u ? (eh + 1) % 24 : (eh + 23) % 24;
        2:       em = u ? (em + 1) % 60 : (em + 59) % 60;
        default: es = u ? (es + 1) % 60 : (es + 59) % 60;
      endcase
    end
    if (acc) c = 0;
    chk({tag, ".load"}, 32'(bus.load), 32'(ld));
    check_all(tag);
    bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    tick();
    c++;
    chk({tag, ".load_off"}, 32'(bus.load), 32'd0);
    repeat (7) tick();
    c += 7;
    check_all({tag, ".after"});
  endtask

  task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.cur_hh = h; bus.cur_mm = m; bus.cur_ss = s;
  endtask

  initial begin
    bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    set_cur(8'h12, 8'h34, 8'h56);
    reset = 1'b1;
    repeat (3) tick();
    chk("rst.load", 32'(bus.load), 32'd0);
    check_all("rst");
    reset = 1'b0;
    tick();

    // Clean press in RUN, then full edit 12:34:56 -> 13:33:56
    do_press(1, 0, 0, "run_mode");
    chk("run_mode.hh", 32'(bus.disp_hh), 32'h12);
    do_press(0, 1, 0, "hh_up");
    do_press(1, 0, 0, "to_mm");
    do_press(0, 0, 1, "mm_dn");
    do_press(1, 0, 0, "to_ss");
    do_press(1, 0, 0, "exit");
    chk("exit.hh", 32'(bus.load_hh), 32'h13);
    chk("exit.mm", 32'(bus.load_mm), 32'h33);
    chk("exit.ss", 32'(bus.load_ss), 32'h56);
    chk("exit.count", 32'(load_seen), 32'(exp_loads));

    // Hour wrap both ways, seconds carry and borrow wrap
    set_cur(8'h23, 8'h00, 8'h09);
    do_press(1, 0, 0, "w_enter");
    do_press(0, 1, 0, "hh_wrap_up");
    chk("hh_wrap_up.v", 32'(bus.disp_hh), 32'h00);
    do_press(0, 0, 1, "hh_wrap_dn");
    chk("hh_wrap_dn.v", 32'(bus.disp_hh), 32'h23);
    do_press(1, 0, 0, "w_mm");
    do_press(1, 0, 0, "w_ss");
    do_press(0, 1, 0, "ss_carry");
    chk("ss_carry.v", 32'(bus.disp_ss), 32'h10);
    do_press(1, 0, 0, "w_exit");
    set_cur(8'h23, 8'h00, 8'h00);
    do_press(1, 0, 0, "w2_enter");
    do_press(1, 0, 0, "w2_mm");
    do_press(1, 0, 0, "w2_ss");
    do_press(0, 0, 1, "ss_wrap_dn");
    chk("ss_wrap_dn.v", 32'(bus.disp_ss), 32'h59);
    do_press(1, 0, 0, "w2_exit");

    // Simultaneous events: mode wins, up+down cancel
    set_cur(8'h07, 8'h45, 8'h30);
    do_press(1, 1, 0, "mode_up");
    do_press(0, 1, 1, "up_dn");
    do_press(1, 0, 1, "mode_dn");

    // Bounce in SET_MM: toggling every 2 cycles never settles
    for (int i = 0; i < 5; i++) begin
      bus.btn_up = 1'b1; repeat (2) tick();
      bus.btn_up = 1'b0; repeat (2) tick();
    end
    repeat (8) tick();
    c += 28;
    check_all("bounce");

    // Blink phase over 20 cycles, then an edit restores visibility
    for (int i = 0; i < 20; i++) begin
      tick();
      c++;
      chk("blink.mask", 32'(bus.blank_mask), 32'(exp_mask()));
    end
    do_press(0, 1, 0, "blink_up");

    // Reset mid-edit discards the edit without a load
    reset = 1'b1;
    tick();
    st = 0; eh = 0; em = 0; es = 0; c = 0;
    check_all("rst_mid");
    chk("rst_mid.load", 32'(bus.load), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_mid.count", 32'(load_seen), 32'(exp_loads));

    // Invalid running time is captured as 00
    set_cur(8'h2A, 8'h60, 8'h17);
    do_press(1, 0, 0, "inv_cap");
    chk("inv_cap.hh", 32'(bus.disp_hh), 32'h00);
    chk("inv_cap.mm", 32'(bus.disp_mm), 32'h00);

    // Random button mixes and running times
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 3) == 0)
          set_cur(8'($urandom), 8'($urandom), 8'($urandom));
        else
          set_cur(to_bcd(int'($urandom_range(0, 23))), to_bcd(int'($urandom_range(0, 59))),
                  to_bcd(int'($urandom_range(0, 59))));
      end
      do_press(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), "rand");
    end
    chk("final.count", 32'(load_seen), 32'(exp_loads));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clock_time_setter.md
Name: clock_time_setter

Overview:
Upstream control stage for the 24-hour clock and the 8-digit segment display. Three raw push-buttons (mode/up/down) are synchronised and debounced. A set-mode FSM lets the user edit hours, minutes and seconds in BCD. On exit it issues a one-cycle load of the edited time into the clock counter. While editing it drives the display time bus and a per-digit blank mask so the field being edited blinks.

Parameters:
DEBOUNCE_CYCLES, 32'd500_000, consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz).
BLINK_CYCLES, 32'd12_500_000, half-period of the edit-field blink (0.25 s at 50 MHz).

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
btn_mode  input  1  raw mode button, asynchronous, active-high.
btn_up  input  1  raw increment button, asynchronous, active-high.
btn_down  input  1  raw decrement button, asynchronous, active-high.
cur_hh  input  8  running clock hours, BCD 00-23.
cur_mm  input  8  running clock minutes, BCD 00-59.
cur_ss  input  8  running clock seconds, BCD 00-59.
setting  output  1  high in any SET state; clock enable is gated with ~setting.
load  output  1  one-cycle strobe that loads load_hh/mm/ss into the clock.
load_hh  output  8  edited hours, BCD.
load_mm  output  8  edited minutes, BCD.
load_ss  output  8  edited seconds, BCD.
disp_hh  output  8  hours to display: cur_hh in RUN, edit value otherwise.
disp_mm  output  8  minutes to display; same rule.
disp_ss  output  8  seconds to display; same rule.
blank_mask  output  8  digit blanking, 1 = blank. Bits 7:6 hh, 4:3 mm, 1:0 ss; bits 5 and 2 (separators) are always 0.

Behaviour:
- Reset is synchronous and active-high on clk. All state is clocked on posedge clk.
- Reset values: state RUN; setting 0; load 0; edit registers 00/00/00 (so load_* = 00); blank_mask 0; blink phase 0; debounce counters 0; stable levels 0; synchroniser flops 0.
- Synchroniser: each button passes through a 2-flop synchroniser.
- Debounce: one counter per button. If the synchronised level equals the stable level, the counter clears. Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, the stable level flips and the counter clears.
- Press event: a 1-cycle pulse in the cycle after the stable level goes 0->1. Releases generate nothing.
- FSM states are RUN, SET_HH, SET_MM, SET_SS.
  - RUN -> SET_HH on a mode press. In that same edge, cur_hh/mm/ss are captured into the edit registers. Any field with an invalid BCD nibble, hh>23 or mm/ss>59 is captured as 00.
  - SET_HH -> SET_MM -> SET_SS on mode presses.
  - SET_SS -> RUN on a mode press; load is high for exactly the next cycle with the edit values.
- Up/down presses act only in SET states, and only on the field of the current state.
  - hh: 23 -> 00 on up; 00 -> 23 on down.
  - mm/ss: 59 -> 00 on up; 00 -> 59 on down.
  - BCD rule: low nibble 9 -> 0 carries into the high nibble; low nibble 0 -> 9 borrows.
- Simultaneous events:
  - up and down pressed in the same cycle: both ignored.
  - mode together with up/down: mode wins, field unchanged.
- In RUN, up/down presses are ignored.
- setting = (state != RUN), decoded combinationally from the state register.
- Blink counter:
  - Runs only in SET states.
  - The blink phase toggles when the counter reaches BLINK_CYCLES-1, then the counter wraps to 0.
  - Counter and phase clear to 0 (field visible) on every state change and on every accepted up/down press.
- blank_mask: the two bits of the current field equal the blink phase; all other bits are 0. In RUN the mask is 0.
- disp_*: a combinational mux of cur_* versus the edit registers, selected on setting.
- Reset while editing: edits are discarded, no load is issued, and the block returns to RUN.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, BLINK_CYCLES=8.)
- Bounce rejection: btn_up toggles every 2 cycles for 20 cycles in SET_MM -> no press event, edit mm unchanged.
- Clean press in RUN:
  - btn_mode held 10 cycles, cur=12:34:56 -> state SET_HH, setting=1, disp=12:34:56.
  - Exactly one press pulse, 2+4+1 cycles after the rising input.
- Wrap:
  - In SET_HH with hh=23: one up press -> 00; then one down press -> 23.
  - In SET_SS with ss=09: up -> 10; then down from 00 -> 59.
- Full set and load:
  - From 12:34:56, press sequence mode, up, mode, down, mode, mode -> load high for exactly 1 cycle with 13:33:56.
  - State RUN and setting=0 in the cycle after the load.
- Blink: in SET_MM, hold for 20 cycles -> blank_mask alternates 8'b00011000 / 8'b00000000 every 8 cycles; an up press restores the mask to 0 immediately.
- Reset mid-edit plus invalid capture:
  - Reset asserted in SET_MM -> next cycle state RUN, load never asserted, edit registers 00.
  - Mode press with cur_hh=8'h2A -> captured hh=00.
